// File: rtl/expr24_eval_engine.sv
// expr24_eval_engine: 24-points evaluator with alternating card/operator entry and an iterative exact divider.
// Define EXPR24_UNDO_EN to add the undo snapshot stack.
module expr24_eval_engine #(
    parameter int N_CARDS = 4,
    parameter int VAL_W   = 4,
    parameter int ACC_W   = 16,
    parameter int TARGET  = 24
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [N_CARDS*VAL_W-1:0] card_val,
    input  logic [N_CARDS-1:0]       key,
    input  logic                     op_plus,
    input  logic                     op_minus,
    input  logic                     op_mult,
    input  logic                     op_div,
    input  logic                     clear,
    input  logic                     undo,
    output logic signed [ACC_W-1:0]  acc,
    output logic [N_CARDS-1:0]       used,
    output logic                     busy,
    output logic                     reject,
    output logic                     done,
    output logic                     win,
    output logic                     err,
    output logic [1:0]               err_code
);
    typedef enum logic [2:0] {FIRST, WAIT_OP, WAIT_OPND, DIV, DONE, ERROR} state_t;
    localparam logic [1:0] OP_SUB = 2'd1, OP_MUL = 2'd2, OP_DIV = 2'd3;
    localparam int CNT_W = $clog2(ACC_W);

    state_t state, state_nx;
    logic [1:0] op, op_code, pop_op;
    logic [3:0] ops;
    logic [VAL_W-1:0] cv, dvs, rem, rem_nx;
    logic [VAL_W:0] r_sh, r_sub;
    logic [N_CARDS-1:0] used_add, pop_used;
    logic key_ok, op_ok, any_in, act, take_key, take_op, rej_nx;
    logic undo_cancel, undo_pop, undo_rej, pop_last;
    logic signed [ACC_W-1:0] pop_acc, alu_res, div_res;
    logic [ACC_W:0] opnd, sum;
    logic [2*ACC_W-1:0] acc_x, prod;
    logic alu_ovf, div_ovf, div_last, q_bit, neg;
    logic [ACC_W-1:0] mag, dvd, quo, q_fin;
    logic [CNT_W-1:0] cnt;

    assign ops      = {op_div, op_mult, op_minus, op_plus};
    assign op_code  = {op_div | op_mult, op_div | op_minus};
    assign any_in   = key != '0 || ops != 4'd0;
    assign key_ok   = key != '0 && (key & (key - 1'b1)) == '0 && (key & used) == '0 && ops == 4'd0;
    assign op_ok    = ops != 4'd0 && (ops & (ops - 4'd1)) == 4'd0 && key == '0;
    assign act      = !(undo_cancel || undo_pop || undo_rej);
    assign take_key = key_ok && act;
    assign take_op  = op_ok && act;
    assign used_add = used | key;

    always_comb begin
        cv = '0;
        for (int i = 0; i < N_CARDS; i++) cv = key[i] ? card_val[i*VAL_W +: VAL_W] : cv;
    end

    // one extra bit catches add/sub overflow; the full double-width product catches mult overflow
    assign opnd    = {{(ACC_W+1-VAL_W){1'b0}}, cv};
    assign sum     = op == OP_SUB ? {acc[ACC_W-1], acc} - opnd : {acc[ACC_W-1], acc} + opnd;
    assign acc_x   = {{ACC_W{acc[ACC_W-1]}}, acc};
    assign prod    = acc_x * {{(2*ACC_W-VAL_W){1'b0}}, cv};
    assign alu_res = op == OP_MUL ? prod[ACC_W-1:0] : sum[ACC_W-1:0];
    assign alu_ovf = op == OP_MUL ? (prod[2*ACC_W-1:ACC_W-1] != '0 && prod[2*ACC_W-1:ACC_W-1] != '1)
                                  : sum[ACC_W] != sum[ACC_W-1];

    // restoring divide on the magnitude, one quotient bit per cycle
    assign mag      = acc[ACC_W-1] ? -acc : acc;
    assign r_sh     = {rem, dvd[ACC_W-1]};
    assign r_sub    = r_sh - {1'b0, dvs};
    assign q_bit    = r_sh >= {1'b0, dvs};
    assign rem_nx   = q_bit ? r_sub[VAL_W-1:0] : r_sh[VAL_W-1:0];
    assign q_fin    = {quo[ACC_W-2:0], q_bit};
    assign div_res  = neg ? -q_fin : q_fin;
    assign div_ovf  = q_fin[ACC_W-1] && !(neg && q_fin[ACC_W-2:0] == '0);
    assign div_last = cnt == CNT_W'(ACC_W - 1);

    assign rej_nx = !clear && (undo_rej || (act && any_in &&
                    ((state == FIRST || state == WAIT_OPND) ? !key_ok :
                     state == WAIT_OP ? !op_ok : state != DIV)));

`ifdef EXPR24_UNDO_EN
    localparam int SP_W = $clog2(N_CARDS + 1);
    localparam int IX_W = N_CARDS > 1 ? $clog2(N_CARDS) : 1;
    logic [SP_W-1:0] sp;
    logic [IX_W-1:0] top;
    logic push;
    logic signed [ACC_W-1:0] stk_acc [N_CARDS];
    logic [N_CARDS-1:0] stk_used [N_CARDS];
    logic [1:0] stk_op [N_CARDS];

    assign push        = take_key && (state == FIRST || state == WAIT_OPND);
    assign top         = IX_W'(sp - 1'b1);
    assign undo_cancel = undo && state == WAIT_OPND;
    assign undo_pop    = undo && sp != '0 && (state == WAIT_OP || state == DONE || state == ERROR);
    assign undo_rej    = undo && state != DIV && !undo_cancel && !undo_pop;
    assign pop_acc     = stk_acc[top];
    assign pop_used    = stk_used[top];
    assign pop_op      = stk_op[top];
    assign pop_last    = sp == SP_W'(1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) sp <= '0;
        else if (clear) sp <= '0;
        else if (push) sp <= sp + 1'b1;
        else if (undo_pop) sp <= sp - 1'b1;
    end

    // snapshot taken before the operand is applied, with the operator that was pending
    always_ff @(posedge clock) begin
        if (push && !clear) begin
            stk_acc[IX_W'(sp)]  <= acc;
            stk_used[IX_W'(sp)] <= used;
            stk_op[IX_W'(sp)]   <= op;
        end
    end
`else
    logic unused_undo;
    assign unused_undo = undo;
    assign undo_cancel = 1'b0;
    assign undo_pop    = 1'b0;
    assign undo_rej    = 1'b0;
    assign pop_acc     = '0;
    assign pop_used    = '0;
    assign pop_op      = '0;
    assign pop_last    = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= FIRST;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            FIRST:     state_nx = !take_key ? FIRST : used_add == '1 ? DONE : WAIT_OP;
            WAIT_OP:   state_nx = take_op ? WAIT_OPND : WAIT_OP;
            WAIT_OPND: state_nx = !take_key ? WAIT_OPND :
                                  op == OP_DIV ? (cv == '0 ? ERROR : DIV) :
                                  alu_ovf ? ERROR : used_add == '1 ? DONE : WAIT_OP;
            DIV:       state_nx = !div_last ? DIV : (rem_nx != '0 || div_ovf) ? ERROR :
                                  used == '1 ? DONE : WAIT_OP;
            DONE:      state_nx = DONE;
            ERROR:     state_nx = ERROR;
            default:   state_nx = FIRST;
        endcase
        if (undo_cancel) state_nx = WAIT_OP;
        if (undo_pop) state_nx = pop_last ? FIRST : WAIT_OPND;
        if (clear) state_nx = FIRST;
    end

    always_comb begin
        busy = state == DIV;
        done = state == DONE;
        err  = state == ERROR;
        win  = done && acc == ACC_W'(TARGET);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc      <= '0;
            used     <= '0;
            reject   <= 1'b0;
            err_code <= 2'd0;
            op       <= 2'd0;
            dvd      <= '0;
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            neg      <= 1'b0;
            cnt      <= '0;
        end else if (clear) begin
            acc      <= '0;
            used     <= '0;
            reject   <= 1'b0;
            err_code <= 2'd0;
        end else begin
            reject <= rej_nx;
            if (state == FIRST && take_key) begin
                acc  <= ACC_W'(cv);
                used <= used_add;
            end
            if (state == WAIT_OP && take_op) op <= op_code;
            if (state == WAIT_OPND && take_key) begin
                used <= used_add;
                if (op == OP_DIV) begin
                    if (cv == '0) err_code <= 2'd1;
                    dvd <= mag;
                    rem <= '0;
                    quo <= '0;
                    dvs <= cv;
                    neg <= acc[ACC_W-1];
                    cnt <= '0;
                end else if (alu_ovf) err_code <= 2'd3;
                else acc <= alu_res;
            end
            if (state == DIV) begin
                dvd <= dvd << 1;
                rem <= rem_nx;
                quo <= q_fin;
                cnt <= cnt + 1'b1;
                if (div_last) begin
                    if (rem_nx != '0) err_code <= 2'd2;
                    else if (div_ovf) err_code <= 2'd3;
                    else acc <= div_res;
                end
            end
            if (undo_pop) begin
                acc      <= pop_acc;
                used     <= pop_used;
                op       <= pop_op;
                err_code <= 2'd0;
            end
        end
    end
endmodule
